// File: rtl/ram_pkg.sv
// Shared definitions for the sync_ram_array storage macro.
//   state_e : clear-sequencer states (IDLE, CLEAR)
//   RD_OLD / RD_NEW : read-during-write policy selectors for RD_MODE
package ram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int RD_OLD = 0;  // same-address read returns prior contents
  localparam int RD_NEW = 1;  // same-address read returns the word being written

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-path delay stage: carries a valid strobe and its data word through
// RD_LAT register stages. Each data register loads only when the valid
// bit entering it is set, so the output word holds between results.
//   clk, rst_n : clock, asynchronous active-low reset
//   valid_i    : a result enters the pipe this cycle
//   data_i     : word accompanying valid_i
//   valid_o    : one-cycle strobe, RD_LAT cycles after valid_i
//   data_o     : last delivered word (held while valid_o = 0)
module ram_rd_pipe #(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic [RD_LAT-1:0] valid_q;
  logic [DATA_W-1:0] data_q [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < RD_LAT; i++) data_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's pre-edge value, which is what makes this a shift pipeline.
      valid_q[0] <= valid_i;
      if (valid_i) data_q[0] <= data_i;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[RD_LAT-1];
  assign data_o  = data_q[RD_LAT-1];

endmodule

// File: rtl/sync_ram_array.sv
// Single-clock RAM, one write port and one read port, DEPTH x DATA_W.
// Adds addressing with range checks, pipelined reads with a valid strobe,
// selectable read-during-write policy and a hardware clear sequencer.
//   clk, rst_n            : clock, asynchronous active-low reset
//   clr_req               : pulse to start clearing every word to INIT_VAL
//   busy                  : high while the clear sequence runs
//   write_en/addr/data    : write port (ignored while busy)
//   read_en/read_addr     : read request (ignored while busy)
//   read_data/read_valid  : read result, valid RD_LAT cycles after request
module sync_ram_array
  import ram_pkg::*;
#(
  parameter int              DATA_W     = 8,
  parameter int              DEPTH      = 16,
  localparam int             ADDR_W     = $clog2(DEPTH),
  parameter int              RD_LAT     = 1,
  parameter int              RD_MODE    = RD_OLD,
  parameter int              CLR_ON_RST = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid
);

  // One extra bit so DEPTH itself is representable for power-of-two sizes.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam state_e          RST_STATE = (CLR_ON_RST != 0) ? CLEAR : IDLE;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  logic              wr_in_range, rd_in_range;
  logic              wr_acc, rd_acc;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_word;

  // busy comes straight from the state register, so it is glitch-free.
  assign busy = (state_q == CLEAR);

  assign wr_in_range = {1'b0, write_addr} < DEPTH_X;
  assign rd_in_range = {1'b0, read_addr}  < DEPTH_X;
  assign wr_acc      = write_en && !busy && wr_in_range;
  assign rd_acc      = read_en  && !busy;

  // Clear sequencer: clr_req is only looked at in IDLE, so a request
  // during CLEAR cannot restart the sweep.
  always_comb begin
    // NOTE: every output of this block gets a default first; a missing
    // assignment on some path would otherwise infer a latch.
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Single physical write port, shared by the clear sweep and the user.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = write_addr;
    mem_wdata = write_data;
    if (busy) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = INIT_VAL;
    end else if (wr_acc) begin
      mem_we = 1'b1;
    end
  end

  // NOTE: the array has no reset so it maps onto RAM macros; its contents
  // are defined only by writes or the clear sweep. While rst_n is held low
  // with CLR_ON_RST set, word 0 is rewritten with INIT_VAL, which the sweep
  // repeats anyway.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Read word entering the pipe: out-of-range addresses read as zero;
  // with RD_NEW a same-address write in this cycle is forwarded.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[read_addr];
      if (RD_MODE == RD_NEW && wr_acc && write_addr == read_addr) begin
        rd_word = write_data;
      end
    end
  end

  ram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (rd_acc),
    .data_i  (rd_word),
    .valid_o (read_valid),
    .data_o  (read_data)
  );

endmodule
